// File: rtl/multicycle_ctrl_if.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_if
//
// This interface groups the signals between the multicycle controller and its
// datapath.
//
// Datapath -> controller (decode fields and status):
//   opcode[6:0]   IR[6:0]
//   funct3[2:0]   IR[14:12]
//   funct7_5      IR[30]
//   alu_zero      ALU zero flag for the current cycle
//   mem_ready     the memory access completes this cycle
//
// Controller -> datapath (enables, selects and ALU command):
//   pc_we, ir_we, adr_src, mem_we, rf_we
//   alu_src_a[1:0], alu_src_b[1:0], result_src[1:0], imm_src[1:0]
//   alu_cmd[3:0], instr_done
//
// Modports:
//   master : the controller side
//   slave  : the datapath side
// ---------------------------------------------------------------------------
interface multicycle_ctrl_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       alu_zero;
  logic       mem_ready;

  logic       pc_we;
  logic       ir_we;
  logic       adr_src;
  logic       mem_we;
  logic       rf_we;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] result_src;
  logic [1:0] imm_src;
  logic [3:0] alu_cmd;
  logic       instr_done;

  modport master (
    input  opcode, funct3, funct7_5, alu_zero, mem_ready,
    output pc_we, ir_we, adr_src, mem_we, rf_we,
           alu_src_a, alu_src_b, result_src, imm_src, alu_cmd, instr_done
  );

  modport slave (
    output opcode, funct3, funct7_5, alu_zero, mem_ready,
    input  pc_we, ir_we, adr_src, mem_we, rf_we,
           alu_src_a, alu_src_b, result_src, imm_src, alu_cmd, instr_done
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
//
// This module is the sequencing controller for a multicycle RV32I-subset
// datapath. The datapath has one shared ALU, one unified instruction/data
// memory, and the IR, PC, OldPC and ALUOut registers. The controller is a
// Moore-style FSM. A state register feeds combinational decode logic, which
// drives every enable, mux select and the ALU command. The controller stalls
// in FETCH, MEMREAD and MEMWRITE until mem_ready is high.
//
// Supported instructions: LW, SW, R-type ALU, I-type ALU, BEQ/BNE, JAL.
//
// Ports:
//   clk     rising-edge clock
//   reset   synchronous, active-high reset
//   bus     multicycle_ctrl_if.master: decode fields and status in,
//           control signals out
//   state   current FSM state, ST_W bits wide (debug)
//   illegal (only when ILLEGAL_TRAP_EN is defined) high while in TRAP
//
// Build option:
//   ILLEGAL_TRAP_EN
//     When this macro is defined, an unrecognised opcode goes to a TRAP state.
//     TRAP is held until reset.
//     When the macro is not defined, an unrecognised opcode completes in
//     DECODE as a NOP.
// ---------------------------------------------------------------------------
module multicycle_ctrl #(
  parameter int ST_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  multicycle_ctrl_if.master   bus,
  output logic [ST_W-1:0]     state
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic                illegal
`endif
);

  // Opcodes
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  // ALU commands
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  // Source-A select
  localparam logic [1:0] A_PC    = 2'b00;
  localparam logic [1:0] A_OLDPC = 2'b01;
  localparam logic [1:0] A_RS1   = 2'b10;

  // Source-B select
  localparam logic [1:0] B_RS2   = 2'b00;
  localparam logic [1:0] B_IMM   = 2'b01;
  localparam logic [1:0] B_FOUR  = 2'b10;

  // Result select
  localparam logic [1:0] R_ALUOUT = 2'b00;
  localparam logic [1:0] R_MEM    = 2'b01;
  localparam logic [1:0] R_ALU    = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10
`ifdef ILLEGAL_TRAP_EN
    ,
    S_TRAP     = 4'd11
`endif
  } state_t;

  state_t state_q;
  state_t state_d;

  // Shared R/I ALU decode. For I-type instructions, funct3=000 is always ADD:
  // IR[30] is part of the immediate there, not a SUB selector.
  function automatic logic [3:0] alu_decode(input logic [2:0] f3,
                                            input logic       f7_5,
                                            input logic       is_r);
    logic [3:0] cmd;
    case (f3)
      3'b000:  cmd = (is_r && f7_5) ? ALU_SUB : ALU_ADD;
      3'b111:  cmd = ALU_AND;
      3'b110:  cmd = ALU_OR;
      3'b100:  cmd = ALU_XOR;
      3'b010:  cmd = ALU_SLT;
      default: cmd = ALU_ADD;
    endcase
    return cmd;
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // The immediate format depends only on the opcode. It is valid in every
  // state, so DECODE can form the branch/jump target without extra logic.
  always_comb begin
    bus.imm_src = 2'b00;
    case (bus.opcode)
      OP_STORE: bus.imm_src = 2'b01;
      OP_BR:    bus.imm_src = 2'b10;
      OP_JAL:   bus.imm_src = 2'b11;
      default:  bus.imm_src = 2'b00;
    endcase
  end

  // Next-state and output decode
  always_comb begin
    state_d        = state_q;
    bus.pc_we      = 1'b0;
    bus.ir_we      = 1'b0;
    bus.adr_src    = 1'b0;
    bus.mem_we     = 1'b0;
    bus.rf_we      = 1'b0;
    bus.alu_src_a  = A_PC;
    bus.alu_src_b  = B_RS2;
    bus.result_src = R_ALUOUT;
    bus.alu_cmd    = ALU_ADD;
    bus.instr_done = 1'b0;

    case (state_q)
      S_FETCH: begin
        // PC+4 goes straight from the ALU into PC. This happens in the same
        // cycle that the IR captures the fetched word.
        bus.adr_src    = 1'b0;
        bus.alu_src_a  = A_PC;
        bus.alu_src_b  = B_FOUR;
        bus.result_src = R_ALU;
        bus.ir_we      = bus.mem_ready;
        bus.pc_we      = bus.mem_ready;
        if (bus.mem_ready) begin
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        // OldPC+imm is computed speculatively. ALUOut then holds the branch or
        // jump target for BRANCH and JAL.
        bus.alu_src_a = A_OLDPC;
        bus.alu_src_b = B_IMM;
        case (bus.opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXEC_R;
          OP_I:              state_d = S_EXEC_I;
          OP_BR:             state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          default: begin
`ifdef ILLEGAL_TRAP_EN
            state_d = S_TRAP;
`else
            bus.instr_done = 1'b1;
            state_d        = S_FETCH;
`endif
          end
        endcase
      end

      S_MEMADR: begin
        bus.alu_src_a = A_RS1;
        bus.alu_src_b = B_IMM;
        state_d = (bus.opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end

      S_MEMREAD: begin
        bus.adr_src = 1'b1;
        if (bus.mem_ready) begin
          state_d = S_MEMWB;
        end
      end

      S_MEMWB: begin
        bus.result_src = R_MEM;
        bus.rf_we      = 1'b1;
        bus.instr_done = 1'b1;
        state_d        = S_FETCH;
      end

      S_MEMWRITE: begin
        // The write strobe stays high for the whole access. The instruction
        // completes only in the cycle the memory accepts it.
        bus.adr_src    = 1'b1;
        bus.result_src = R_ALUOUT;
        bus.mem_we     = 1'b1;
        if (bus.mem_ready) begin
          bus.instr_done = 1'b1;
          state_d        = S_FETCH;
        end
      end

      S_EXEC_R: begin
        bus.alu_src_a = A_RS1;
        bus.alu_src_b = B_RS2;
        bus.alu_cmd   = alu_decode(bus.funct3, bus.funct7_5, 1'b1);
        state_d       = S_ALUWB;
      end

      S_EXEC_I: begin
        bus.alu_src_a = A_RS1;
        bus.alu_src_b = B_IMM;
        bus.alu_cmd   = alu_decode(bus.funct3, bus.funct7_5, 1'b0);
        state_d       = S_ALUWB;
      end

      S_ALUWB: begin
        bus.result_src = R_ALUOUT;
        bus.rf_we      = 1'b1;
        bus.instr_done = 1'b1;
        state_d        = S_FETCH;
      end

      S_BRANCH: begin
        // rs1-rs2 sets alu_zero. The target from DECODE sits in ALUOut and is
        // loaded into PC only when the branch is taken. Any funct3 other than
        // BEQ or BNE falls through as not taken.
        bus.alu_src_a  = A_RS1;
        bus.alu_src_b  = B_RS2;
        bus.alu_cmd    = ALU_SUB;
        bus.result_src = R_ALUOUT;
        bus.pc_we      = ((bus.funct3 == 3'b000) &&  bus.alu_zero) ||
                         ((bus.funct3 == 3'b001) && !bus.alu_zero);
        bus.instr_done = 1'b1;
        state_d        = S_FETCH;
      end

      S_JAL: begin
        // PC takes the target from ALUOut. In the same cycle the ALU computes
        // OldPC+4, which ALUWB writes to rd.
        bus.alu_src_a  = A_OLDPC;
        bus.alu_src_b  = B_FOUR;
        bus.result_src = R_ALUOUT;
        bus.pc_we      = 1'b1;
        state_d        = S_ALUWB;
      end

`ifdef ILLEGAL_TRAP_EN
      S_TRAP: begin
        state_d = S_TRAP;
      end
`endif

      default: begin
        state_d = S_FETCH;
      end
    endcase

    // While reset is high, architectural writes are suppressed. An
    // instruction that reset abandons therefore leaves no partial update.
    if (reset) begin
      bus.pc_we      = 1'b0;
      bus.ir_we      = 1'b0;
      bus.mem_we     = 1'b0;
      bus.rf_we      = 1'b0;
      bus.instr_done = 1'b0;
    end
  end

  assign state = ST_W'(state_q);

`ifdef ILLEGAL_TRAP_EN
  assign illegal = (state_q == S_TRAP);
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl
//
// This bench exercises multicycle_ctrl with directed and randomised
// instructions. For each instruction it builds the expected per-cycle
// behaviour from the instruction's cycle recipe: fetch, decode, then the
// class-specific cycles, with explicit stall cycles. The bench also draws the
// random mem_ready/alu_zero values for every cycle. It then replays the cycles
// and compares every output on every cycle.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;

  localparam logic [3:0] ADD = 4'b0010;
  localparam logic [3:0] SUB = 4'b0110;
  localparam logic [3:0] AND_ = 4'b0000;
  localparam logic [3:0] OR_  = 4'b0001;
  localparam logic [3:0] XOR_ = 4'b0011;
  localparam logic [3:0] SLT  = 4'b0111;

  localparam int K_LW = 0, K_SW = 1, K_R = 2, K_I = 3, K_BR = 4, K_JAL = 5, K_ILL = 6;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_ctrl_if bus();
  logic [3:0] state_w;
`ifdef ILLEGAL_TRAP_EN
  logic illegal;
`endif

  multicycle_ctrl #(.ST_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .state (state_w)
`ifdef ILLEGAL_TRAP_EN
    ,
    .illegal (illegal)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [3:0] st;
    logic       pc_we;
    logic       ir_we;
    logic       adr;
    logic       mw;
    logic       rf;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] rs;
    logic [3:0] cmd;
    logic       done;
    logic       mr;
    logic       az;
  } step_t;

  step_t q[$];

  function automatic step_t mk(input logic [3:0] st, input logic pc, input logic ir,
                               input logic adr, input logic mw, input logic rf,
                               input logic [1:0] a, input logic [1:0] b, input logic [1:0] rs,
                               input logic [3:0] cmd, input logic done,
                               input logic mr, input logic az);
    step_t s;
    s.st = st; s.pc_we = pc; s.ir_we = ir; s.adr = adr; s.mw = mw; s.rf = rf;
    s.a = a; s.b = b; s.rs = rs; s.cmd = cmd; s.done = done; s.mr = mr; s.az = az;
    return s;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [1:0] imm_of(input logic [6:0] op);
    case (op)
      7'b0100011: return 2'b01;
      7'b1100011: return 2'b10;
      7'b1101111: return 2'b11;
      default:    return 2'b00;
    endcase
  endfunction

  // ALU operation named by the instruction's funct3/funct7 fields
  function automatic logic [3:0] op_of(input logic [2:0] f3, input logic f75, input logic is_r);
    case (f3)
      3'd0:    return (is_r && f75) ? SUB : ADD;
      3'd7:    return AND_;
      3'd6:    return OR_;
      3'd4:    return XOR_;
      3'd2:    return SLT;
      default: return ADD;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Replays the queued cycles. On each falling edge it drives the inputs, then
  // it checks all outputs 1 time unit later.
  task automatic run_queue(input string tag, input logic [6:0] op,
                           input logic [2:0] f3, input logic f75);
    step_t s;
    int cyc;
    logic [21:0] obs, exp;
    cyc = 0;
    while (q.size() > 0) begin
      s = q.pop_front();
      @(negedge clk);
      reset         = 1'b0;
      bus.opcode    = op;
      bus.funct3    = f3;
      bus.funct7_5  = f75;
      bus.mem_ready = s.mr;
      bus.alu_zero  = s.az;
      #1;
      obs = {state_w, bus.pc_we, bus.ir_we, bus.adr_src, bus.mem_we, bus.rf_we,
             bus.alu_src_a, bus.alu_src_b, bus.result_src, bus.imm_src, bus.alu_cmd,
             bus.instr_done};
      exp = {s.st, s.pc_we, s.ir_we, s.adr, s.mw, s.rf, s.a, s.b, s.rs,
             imm_of(op), s.cmd, s.done};
      check($sformatf("%s cyc%0d", tag, cyc), 32'(obs), 32'(exp));
`ifdef ILLEGAL_TRAP_EN
      check($sformatf("%s cyc%0d illegal", tag, cyc), 32'(illegal), 32'(s.st == 4'd11));
`endif
      cyc++;
    end
    $display("instr %s op=%b f3=%b f7_5=%b cycles=%0d", tag, op, f3, f75, cyc);
  endtask

  // Builds the expected cycles for one instruction. cut>0 keeps only the
  // first cut cycles so that reset can be applied mid-instruction.
  task automatic do_instr(input string tag, input int kind, input logic [2:0] f3,
                          input logic f75, input int fstall, input int mstall,
                          input logic az, input logic [6:0] ill_op, input int cut);
    logic [6:0] op;
    logic taken;
    case (kind)
      K_LW:    op = 7'b0000011;
      K_SW:    op = 7'b0100011;
      K_R:     op = 7'b0110011;
      K_I:     op = 7'b0010011;
      K_BR:    op = 7'b1100011;
      K_JAL:   op = 7'b1101111;
      default: op = ill_op;
    endcase
    q.delete();
    for (int i = 0; i < fstall; i++)
      q.push_back(mk(4'd0, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd2, ADD, 0, 1'b0, rb()));
    q.push_back(mk(4'd0, 1, 1, 0, 0, 0, 2'd0, 2'd2, 2'd2, ADD, 0, 1'b1, rb()));
`ifdef ILLEGAL_TRAP_EN
    q.push_back(mk(4'd1, 0, 0, 0, 0, 0, 2'd1, 2'd1, 2'd0, ADD, 0, rb(), rb()));
`else
    q.push_back(mk(4'd1, 0, 0, 0, 0, 0, 2'd1, 2'd1, 2'd0, ADD, kind == K_ILL, rb(), rb()));
`endif
    case (kind)
      K_LW: begin
        q.push_back(mk(4'd2, 0, 0, 0, 0, 0, 2'd2, 2'd1, 2'd0, ADD, 0, rb(), rb()));
        for (int i = 0; i < mstall; i++)
          q.push_back(mk(4'd3, 0, 0, 1, 0, 0, 2'd0, 2'd0, 2'd0, ADD, 0, 1'b0, rb()));
        q.push_back(mk(4'd3, 0, 0, 1, 0, 0, 2'd0, 2'd0, 2'd0, ADD, 0, 1'b1, rb()));
        q.push_back(mk(4'd4, 0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd1, ADD, 1, rb(), rb()));
      end
      K_SW: begin
        q.push_back(mk(4'd2, 0, 0, 0, 0, 0, 2'd2, 2'd1, 2'd0, ADD, 0, rb(), rb()));
        for (int i = 0; i < mstall; i++)
          q.push_back(mk(4'd5, 0, 0, 1, 1, 0, 2'd0, 2'd0, 2'd0, ADD, 0, 1'b0, rb()));
        q.push_back(mk(4'd5, 0, 0, 1, 1, 0, 2'd0, 2'd0, 2'd0, ADD, 1, 1'b1, rb()));
      end
      K_R, K_I: begin
        q.push_back(mk((kind == K_R) ? 4'd6 : 4'd7, 0, 0, 0, 0, 0, 2'd2,
                       (kind == K_R) ? 2'd0 : 2'd1, 2'd0,
                       op_of(f3, f75, kind == K_R), 0, rb(), rb()));
        q.push_back(mk(4'd8, 0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, ADD, 1, rb(), rb()));
      end
      K_BR: begin
        taken = (f3 == 3'd0 && az) || (f3 == 3'd1 && !az);
        q.push_back(mk(4'd9, taken, 0, 0, 0, 0, 2'd2, 2'd0, 2'd0, SUB, 1, rb(), az));
      end
      K_JAL: begin
        q.push_back(mk(4'd10, 1, 0, 0, 0, 0, 2'd1, 2'd2, 2'd0, ADD, 0, rb(), rb()));
        q.push_back(mk(4'd8, 0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, ADD, 1, rb(), rb()));
      end
      default: begin
`ifdef ILLEGAL_TRAP_EN
        for (int i = 0; i < 4; i++)
          q.push_back(mk(4'd11, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, ADD, 0, rb(), rb()));
`endif
      end
    endcase
    if (cut > 0)
      while (q.size() > cut) void'(q.pop_back());
    run_queue(tag, op, f3, f75);
  endtask

  // Holds reset for n cycles and checks that every write enable stays low.
  task automatic reset_cycles(input string tag, input int n, input logic mr);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset = 1'b1;
      bus.mem_ready = mr;
      #1;
      check($sformatf("%s rst%0d", tag, i), 32'({bus.pc_we, bus.ir_we, bus.mem_we,
                                                 bus.rf_we, bus.instr_done}), 32'd0);
      $display("reset %s cycle %0d", tag, i);
    end
  endtask

  initial begin
    int kind, nk, fs, ms;
    logic [6:0] ill_ops [4];
    ill_ops = '{7'h7f, 7'h37, 7'h17, 7'h00};
    reset = 1'b1;
    bus.opcode = 7'b0000011;
    bus.funct3 = 3'd0;
    bus.funct7_5 = 1'b0;
    bus.alu_zero = 1'b0;
    bus.mem_ready = 1'b1;

    reset_cycles("por", 2, 1'b1);

    // Directed cases from the intended behaviour
    do_instr("lw_stall2",  K_LW,  3'd2, 1'b0, 0, 2, 1'b0, 7'h0, 0);
    do_instr("sub",        K_R,   3'd0, 1'b1, 0, 0, 1'b0, 7'h0, 0);
    do_instr("addi_f7",    K_I,   3'd0, 1'b1, 0, 0, 1'b0, 7'h0, 0);
    do_instr("beq_t",      K_BR,  3'd0, 1'b0, 0, 0, 1'b1, 7'h0, 0);
    do_instr("beq_nt",     K_BR,  3'd0, 1'b0, 0, 0, 1'b0, 7'h0, 0);
    do_instr("bne_t",      K_BR,  3'd1, 1'b0, 0, 0, 1'b0, 7'h0, 0);
    do_instr("sw_stall3",  K_SW,  3'd2, 1'b0, 1, 3, 1'b0, 7'h0, 0);
    do_instr("jal",        K_JAL, 3'd0, 1'b0, 0, 0, 1'b0, 7'h0, 0);
    do_instr("xor",        K_R,   3'd4, 1'b0, 0, 0, 1'b0, 7'h0, 0);
    do_instr("slti",       K_I,   3'd2, 1'b0, 0, 0, 1'b0, 7'h0, 0);
`ifndef ILLEGAL_TRAP_EN
    do_instr("ill_nop",    K_ILL, 3'd0, 1'b0, 0, 0, 1'b0, 7'h7f, 0);
`endif

    // A store is abandoned mid-write. mem_we must drop while reset is high.
    do_instr("sw_abort",   K_SW,  3'd2, 1'b0, 0, 3, 1'b0, 7'h0, 5);
    reset_cycles("abort", 1, 1'b0);

    // Random instruction mix
`ifdef ILLEGAL_TRAP_EN
    nk = 5;
`else
    nk = 6;
`endif
    for (int n = 0; n < 200; n++) begin
      kind = $urandom_range(0, nk);
      fs = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      ms = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
      do_instr($sformatf("rnd%0d", n), kind, 3'($urandom_range(0, 7)), rb(), fs, ms,
               rb(), ill_ops[$urandom_range(0, 3)], 0);
    end

`ifdef ILLEGAL_TRAP_EN
    do_instr("trap", K_ILL, 3'd0, 1'b0, 0, 0, 1'b0, 7'h7f, 0);
    reset_cycles("trap_exit", 1, 1'b1);
    do_instr("after_trap", K_R, 3'd7, 1'b0, 0, 0, 1'b0, 7'h0, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Sequencing controller for the multicycle RV32I-subset datapath: one shared ALU, one unified instruction/data memory, IR, PC, OldPC and ALUOut registers.
- Moore-style FSM: state register plus combinational decode. Drives all register/memory write enables, mux selects and the ALU command.
- Stalls on a memory-ready handshake.
- Supports: load (LW), store (SW), R-type, I-type ALU, BEQ/BNE, JAL.

Parameters:
- ST_W, 4, state register width (exposed on debug port).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  7  IR[6:0].
- funct3  in  3  IR[14:12].
- funct7_5  in  1  IR[30].
- alu_zero  in  1  ALU zero flag, combinational from the current cycle.
- mem_ready  in  1  memory access completes this cycle.
- pc_we  out  1  PC write enable.
- ir_we  out  1  IR and OldPC write enable.
- adr_src  out  1  memory address select: 0=PC, 1=ALUOut.
- mem_we  out  1  memory write enable.
- rf_we  out  1  register file write enable.
- alu_src_a  out  2  00=PC, 01=OldPC, 10=rs1.
- alu_src_b  out  2  00=rs2, 01=imm, 10=constant 4.
- result_src  out  2  00=ALUOut, 01=MemData, 10=ALU result.
- imm_src  out  2  00=I, 01=S, 10=B, 11=J; decoded from opcode in every state.
- alu_cmd  out  4  0010 ADD, 0110 SUB, 0000 AND, 0001 OR, 0011 XOR, 0111 SLT.
- instr_done  out  1  one-cycle pulse on the final cycle of each instruction.
- state  out  ST_W  current state (debug).

Behaviour:
- States: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXEC_R=6, EXEC_I=7, ALUWB=8, BRANCH=9, JAL=10, TRAP=11.
- Unlisted outputs are 0 in every state. alu_cmd=ADD unless stated.
- Reset:
  - state<=FETCH on the next edge.
  - While reset is high, pc_we, ir_we, mem_we, rf_we and instr_done are forced 0.
  - After reset: FETCH outputs with enables low until mem_ready.
  - Reset mid-instruction abandons it with no partial writes after the reset edge.
- FETCH:
  - adr_src=0, a=00, b=10, result_src=10.
  - ir_we=pc_we=mem_ready.
  - Stays in FETCH while !mem_ready; goes to DECODE on mem_ready.
- DECODE:
  - a=01, b=01 (branch/jump target into ALUOut).
  - Next state by opcode: 0000011 or 0100011 -> MEMADR; 0110011 -> EXEC_R; 0010011 -> EXEC_I; 1100011 -> BRANCH; 1101111 -> JAL; other -> illegal handling (see Optional Feature).
- MEMADR: a=10, b=01. Next MEMREAD if opcode=0000011, else MEMWRITE.
- MEMREAD: adr_src=1. Holds until mem_ready, then MEMWB.
- MEMWB: result_src=01, rf_we=1, instr_done=1. Next FETCH.
- MEMWRITE:
  - adr_src=1, result_src=00, mem_we=1 held every cycle until mem_ready.
  - instr_done=1 in the mem_ready cycle, then FETCH.
- EXEC_R: a=10, b=00, alu_cmd from R decode. Next ALUWB.
- EXEC_I: a=10, b=01, alu_cmd from I decode. Next ALUWB.
- ALUWB: result_src=00, rf_we=1, instr_done=1. Next FETCH.
- BRANCH:
  - a=10, b=00, alu_cmd=SUB, result_src=00.
  - pc_we = (funct3==000 & alu_zero) | (funct3==001 & !alu_zero). Other funct3 values give not taken.
  - instr_done=1. Next FETCH.
- JAL:
  - a=01, b=10 (OldPC+4 into ALUOut), result_src=00 (previous target), pc_we=1.
  - Next ALUWB (writes rd=OldPC+4).
- R decode:
  - funct3 000 -> SUB if funct7_5 else ADD.
  - 111 AND; 110 OR; 100 XOR; 010 SLT; others ADD.
- I decode: same as R decode, except 000 is always ADD (funct7_5 ignored).
- Cycle counts with mem_ready always high:
  - LW 5; SW 4; R-type and I-type 4; branch 3; JAL 4.
- Each mem_ready low cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.
- mem_ready is ignored in all other states.

Optional Feature:
- Macro ILLEGAL_TRAP_EN.
- Defined: an unrecognised opcode in DECODE goes to TRAP. TRAP has all enables 0 and instr_done=0, and is held until reset. Adds output illegal (1 bit), 1 only in TRAP.
- Undefined: an unrecognised opcode in DECODE is a NOP: instr_done=1 in DECODE, then FETCH. No TRAP state, no illegal port.

Test Plan:
- Reset held 2 cycles with mem_ready=1, then released -> all enables 0 during reset; next cycle state=0 with ir_we=pc_we=1.
- LW (opcode 0000011), mem_ready low for 2 cycles in MEMREAD -> states 0,1,2,3,3,3,4. rf_we=1 with result_src=01 only in state 4. instr_done single pulse.
- R-type SUB (0110011, funct3=000, funct7_5=1) -> alu_cmd=0110 in EXEC_R. I-type with funct7_5=1, funct3=000 -> alu_cmd=0010.
- BEQ with alu_zero=1 -> pc_we=1 in BRANCH. BEQ with alu_zero=0 -> pc_we=0. BNE with alu_zero=0 -> pc_we=1. Each takes 3 cycles.
- SW with mem_ready low for 3 cycles -> mem_we=1 for 4 consecutive cycles, adr_src=1 throughout, then FETCH.
- Opcode 1111111 -> with ILLEGAL_TRAP_EN: state=11, illegal=1, stays until reset. Without it: DECODE pulses instr_done, then FETCH.
